// File: rtl/gmii_rx_frame_parser_pkg.sv
// ----------------------------------------------------------------------------
// gmii_rx_frame_parser_pkg
// Shared constants and types for the GMII receive frame parser and its CRC
// helper: preamble/SFD byte and nibble values, CRC-32 init/residue/polynomial,
// delay-line depth, FSM state encoding and the registered output record.
// ----------------------------------------------------------------------------
package gmii_rx_frame_parser_pkg;

    localparam logic [7:0]  PREAMBLE_B    = 8'h55;
    localparam logic [7:0]  SFD_B         = 8'hD5;
    localparam logic [3:0]  PREAMBLE_N    = 4'h5;
    localparam logic [3:0]  SFD_N         = 4'hD;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    // Reflected form of 0x04C11DB7, used for LSB-first shifting.
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    // One pending output byte plus the four FCS bytes held back.
    localparam int          DLY_DEPTH     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
        logic       ok;
        logic       crc_err;
    } rx_out_t;

endpackage

// File: rtl/gmii_rx_frame_parser_if.sv
// ----------------------------------------------------------------------------
// gmii_rx_frame_parser_if
// Bundles the GMII receive inputs and the framed byte-stream outputs.
//   gmii_rxd/gmii_rx_dv/gmii_rx_er : GMII receive data, data valid, error
//   rx_data/rx_valid               : payload byte and its 1-cycle strobe
//   rx_sof/rx_eof/rx_err           : frame markers, error flag with eof
//   frame_ok/crc_err               : status pulses coincident with eof
// slave  : the parser (consumes GMII, produces the byte stream)
// master : the PHY side / downstream consumer
// ----------------------------------------------------------------------------
interface gmii_rx_frame_parser_if;

    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    logic       rx_err;
    logic       frame_ok;
    logic       crc_err;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, frame_ok, crc_err
    );

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output rx_data, rx_valid, rx_sof, rx_eof, rx_err, frame_ok, crc_err
    );

endinterface

// File: rtl/gmii_rx_frame_parser_crc32_d8.sv
// ----------------------------------------------------------------------------
// gmii_rx_frame_parser_crc32_d8
// Combinational next-state of the Ethernet CRC-32 (reflected, LSB first) for
// one data byte. No final inversion; callers own init and residue handling.
//   crc_i  [31:0] : current CRC register
//   data_i [7:0]  : byte to absorb, bit 0 first
//   crc_o  [31:0] : CRC register after the byte
// ----------------------------------------------------------------------------
module gmii_rx_frame_parser_crc32_d8
    import gmii_rx_frame_parser_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_o[0] ^ data_i[i]) begin
                crc_o = (crc_o >> 1) ^ CRC_POLY_REFL;
            end else begin
                crc_o = crc_o >> 1;
            end
        end
    end

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// ----------------------------------------------------------------------------
// gmii_rx_frame_parser
// Turns the GMII receive stream into a framed byte stream: nibble assembly at
// 10/100, preamble/SFD strip, FCS strip via a 5-byte delay line, CRC-32 check,
// runt/oversize/dribble/rx_er checks. No backpressure.
//   rx_clk_i       : receive clock, the only clock
//   rx_reset_i     : synchronous active-high reset
//   speed_10_100_i : 1 = nibble mode (low nibble first), 0 = byte mode
//   bus            : GMII inputs and framed outputs (slave side)
// MIN_LEN/MAX_LEN count DA..FCS inclusive.
// ----------------------------------------------------------------------------
module gmii_rx_frame_parser
    import gmii_rx_frame_parser_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic                   rx_clk_i,
    input  logic                   rx_reset_i,
    input  logic                   speed_10_100_i,
    gmii_rx_frame_parser_if.slave  bus
);

    rx_state_e       state_q, state_d;
    logic [31:0]     crc_q, crc_d, crc_next;
    logic [15:0]     len_q, len_d;
    logic            phase_q, phase_d;
    logic [3:0]      nib_lo_q, nib_lo_d;
    logic [2:0]      fill_q, fill_d;
    logic [4:0][7:0] dly_q, dly_d;
    logic            er_seen_q, er_seen_d;
    logic            sof_pend_q, sof_pend_d;
    logic            valid_q, valid_d;
    rx_out_t         out_q, out_d;

    logic [7:0]      byte_val;
    logic            pre_match, sfd_match, line_full, crc_bad, frame_err;

    // In nibble mode the second nibble completes the byte; the first was parked.
    assign byte_val  = speed_10_100_i ? {bus.gmii_rxd[3:0], nib_lo_q} : bus.gmii_rxd;
    assign pre_match = speed_10_100_i ? (bus.gmii_rxd[3:0] == PREAMBLE_N) : (bus.gmii_rxd == PREAMBLE_B);
    assign sfd_match = speed_10_100_i ? (bus.gmii_rxd[3:0] == SFD_N)      : (bus.gmii_rxd == SFD_B);
    assign line_full = (fill_q == 3'(DLY_DEPTH));
    assign crc_bad   = (crc_q != CRC_RESIDUE);
    // phase_q set at end of frame means a lone trailing nibble (dribble).
    assign frame_err = crc_bad | er_seen_q | (len_q < 16'(MIN_LEN)) | phase_q;

    gmii_rx_frame_parser_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (byte_val),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        len_d      = len_q;
        phase_d    = phase_q;
        nib_lo_d   = nib_lo_q;
        fill_d     = fill_q;
        dly_d      = dly_q;
        er_seen_d  = er_seen_q;
        sof_pend_d = sof_pend_q;
        valid_d    = 1'b0;
        out_d      = '0;
        out_d.data = out_q.data;

        case (state_q)
            ST_IDLE: begin
                if (bus.gmii_rx_dv && pre_match) state_d = ST_PRE;
            end
            ST_PRE: begin
                if (!bus.gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (sfd_match) begin
                    state_d    = ST_DATA;
                    crc_d      = CRC_INIT;
                    len_d      = '0;
                    phase_d    = 1'b0;
                    fill_d     = '0;
                    er_seen_d  = 1'b0;
                    sof_pend_d = 1'b1;
                end else if (!pre_match) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!bus.gmii_rx_dv) begin
                    state_d = ST_IDLE;
                    // Frames shorter than the delay line never surface.
                    if (line_full) begin
                        valid_d       = 1'b1;
                        out_d.data    = dly_q[4];
                        out_d.sof     = sof_pend_q;
                        out_d.eof     = 1'b1;
                        out_d.err     = frame_err;
                        out_d.ok      = ~frame_err;
                        out_d.crc_err = crc_bad;
                    end
                end else begin
                    if (bus.gmii_rx_er) er_seen_d = 1'b1;
                    if (speed_10_100_i && !phase_q) begin
                        nib_lo_d = bus.gmii_rxd[3:0];
                        phase_d  = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        crc_d   = crc_next;
                        len_d   = len_q + 16'd1;
                        dly_d   = {dly_q[3:0], byte_val};
                        if (!line_full) fill_d = fill_q + 3'd1;
                        if (line_full) begin
                            valid_d    = 1'b1;
                            out_d.data = dly_q[4];
                            out_d.sof  = sof_pend_q;
                            sof_pend_d = 1'b0;
                            // Oversize: close the frame on the byte being pushed
                            // out. CRC is not judged on a truncated frame.
                            if (len_q == 16'(MAX_LEN)) begin
                                out_d.eof = 1'b1;
                                out_d.err = 1'b1;
                                state_d   = ST_DROP;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!bus.gmii_rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk_i) begin
        if (rx_reset_i) begin
            state_q    <= ST_IDLE;
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            phase_q    <= 1'b0;
            nib_lo_q   <= '0;
            fill_q     <= '0;
            dly_q      <= '0;
            er_seen_q  <= 1'b0;
            sof_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            phase_q    <= phase_d;
            nib_lo_q   <= nib_lo_d;
            fill_q     <= fill_d;
            dly_q      <= dly_d;
            er_seen_q  <= er_seen_d;
            sof_pend_q <= sof_pend_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
        end
    end

    assign bus.rx_data  = out_q.data;
    assign bus.rx_valid = valid_q;
    assign bus.rx_sof   = out_q.sof;
    assign bus.rx_eof   = out_q.eof;
    assign bus.rx_err   = out_q.err;
    assign bus.frame_ok = out_q.ok;
    assign bus.crc_err  = out_q.crc_err;

endmodule
